// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues one read per cycle
// to a one-cycle-latency instruction memory, buffers returned words in a
// small prefetch FIFO drained by the datapath, and restarts on redirects.
module instr_fetch_ctrl #(
  parameter int                NUM_INSTR  = 32,
  parameter int                ADDR_W     = $clog2(NUM_INSTR) * 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2,
  parameter int                INSTR_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_instr,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  entry_t             fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [ADDR_W-1:0]  pc_fetch_q;
  logic [ADDR_W-1:0]  inflight_pc_q;
  logic               inflight_q;
  entry_t             hold_q;

  entry_t             head;
  logic               pop;
  logic               push;
  logic               issue;
  logic [CNT_W:0]     occ;
  logic [ADDR_W-1:0]  redirect_addr;

  // Head selection, handshake decode and issue decision.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    head          = hold_q;
    pop           = 1'b0;
    push          = 1'b0;
    issue         = 1'b0;
    occ           = '0;
    redirect_addr = {redirect_pc[ADDR_W-1:2], 2'b00};
    instr_valid   = 1'b0;
    instr         = '0;
    instr_pc      = '0;
    mem_en        = 1'b0;
    mem_addr      = RESET_PC;

    // An empty FIFO keeps showing whatever was last on the head.
    if (count_q != '0) head = fifo_q[rd_ptr_q];

    if (!rst) begin
      instr_valid = (count_q != '0);
      instr       = head.instr;
      instr_pc    = head.pc;
      pop         = instr_valid && instr_ready;
      push        = inflight_q && !redirect_valid;
      // Slots still committed after this edge: stored + returning - leaving.
      occ         = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
      issue       = fetch_en && (occ < (CNT_W+1)'(FIFO_DEPTH));
      if (redirect_valid) begin
        mem_en   = fetch_en;
        mem_addr = redirect_addr;
      end else begin
        mem_en   = issue;
        mem_addr = pc_fetch_q;
      end
    end
  end

  // Control state: fetch PC, in-flight tracking, FIFO pointers and count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    if (rst) begin
      pc_fetch_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      hold_q        <= '0;
    end else begin
      hold_q <= head;
      if (redirect_valid) begin
        count_q       <= '0;
        rd_ptr_q      <= '0;
        wr_ptr_q      <= '0;
        inflight_q    <= fetch_en;
        inflight_pc_q <= redirect_addr;
        pc_fetch_q    <= fetch_en ? redirect_addr + ADDR_W'(4) : redirect_addr;
      end else begin
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        count_q    <= count_q + CNT_W'(push) - CNT_W'(pop);
        inflight_q <= issue;
        if (issue) begin
          inflight_pc_q <= pc_fetch_q;
          pc_fetch_q    <= pc_fetch_q + ADDR_W'(4);
        end
      end
    end
  end

  // Prefetch storage: captures each returning word with its address.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; count_q alone says which
    // entries are meaningful, so stale contents are never observed.
    if (push) fifo_q[wr_ptr_q] <= '{instr: mem_instr, pc: inflight_pc_q};
  end

endmodule
